gen_sequencer: RTL and testbench
================================

GEN_SEQUENCER -- requirements
Module: gen_sequencer

Interface
REQ-001 Parameter N_POS, default 4, number of array positions swept per generation (2..2^POS_W).
REQ-002 Parameter POS_W, default 2, width of the position index.
REQ-003 Parameter GEN_W, default 16, width of the generation counter.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  free-run request; while high, generations follow back to back.
REQ-007 step  input  1  single-cycle pulse requesting exactly one generation from HALT.
REQ-008 mem_ready  input  1  memory accepts the current write_mem cycle.
REQ-009 write_array  output  1  high in WRARR phase.
REQ-010 run  output  1  high in RUN phase.
REQ-011 write_mem  output  1  high in WRMEM phase.
REQ-012 pos  output  POS_W  current position index.
REQ-013 busy  output  1  high in any state other than HALT.
REQ-014 gen_done  output  1  one-cycle pulse when a generation completes.
REQ-015 gen_count  output  GEN_W  completed generations, modulo 2^GEN_W.

Function
REQ-016 FSM states SHALL be HALT, LOAD, WRARR, RUN, WRMEM; strobes SHALL be registered, mutually exclusive and all low in HALT and LOAD.
REQ-017 HALT -> LOAD with pos=0 on the first cycle where step=1 or enable=1.
REQ-018 LOAD -> WRARR -> RUN SHALL each take exactly one cycle.
REQ-019 RUN -> WRMEM unconditionally; WRMEM SHALL hold, with pos and write_mem stable, until mem_ready=1.
REQ-020 WRMEM with mem_ready=1 and pos<N_POS-1 -> LOAD with pos+1.
REQ-021 WRMEM with mem_ready=1 and pos=N_POS-1 SHALL increment gen_count, pulse gen_done in the next cycle, and reset pos to 0.
REQ-022 At generation end, next state SHALL be LOAD if enable=1 in that cycle, else HALT.
REQ-023 enable falling mid-generation SHALL NOT abort; the current generation completes, then HALT.
REQ-024 step outside HALT SHALL be ignored; step and enable together in HALT start one generation and then follow REQ-022.
REQ-025 With mem_ready tied high, one generation SHALL take exactly 4*N_POS cycles from first LOAD to gen_done.
REQ-026 gen_count SHALL wrap from 2^GEN_W-1 to 0 without a flag.
REQ-027 pos SHALL never exceed N_POS-1; unused encodings are unreachable.

Reset
REQ-028 reset=1 SHALL immediately force HALT, pos=0, gen_count=0, all strobes, busy and gen_done low, independent of clk.
REQ-029 Reset mid-generation SHALL discard the partial generation without a gen_done pulse.
REQ-030 After reset release, the first start SHALL require a fresh step or enable=1 sample.

Configuration
REQ-031 Macro GEN_SEQUENCER_GEN_COUNT_EN SHALL compile in the generation counter.
REQ-032 Without GEN_SEQUENCER_GEN_COUNT_EN, gen_count SHALL be driven constant 0, no counter flops exist, and gen_done and all other behaviour are unchanged.

Structure
REQ-033 Shared package life_pkg SHALL hold the FSM state enumeration and default parameter constants.
REQ-034 Generation counter SHALL be a sub-module gen_counter (async reset, increment enable, wrap), instantiated only under the macro.

Verification
REQ-035 N_POS=4, mem_ready=1, step pulse -> strobes per position LOAD,WRARR,RUN,WRMEM for pos 0..3, gen_done after 16 cycles, gen_count=1, then HALT.
REQ-036 enable=1 for 3 generations then low -> gen_count=3, three gen_done pulses 16 cycles apart, busy drops after the third.
REQ-037 mem_ready low for 5 cycles in WRMEM at pos=2 -> write_mem held 6 cycles, pos=2 stable, generation takes 21 cycles.
REQ-038 reset asserted asynchronously in RUN at pos=1 -> outputs zero before the next clk edge, no gen_done, gen_count=0.
REQ-039 GEN_W=2, enable=1 for 5 generations -> gen_count sequence 1,2,3,0,1.
REQ-040 step pulsed while busy -> ignored; build without macro -> gen_count stays 0 while gen_done still pulses.

Source files
------------

// File: rtl/life_pkg.sv
// Shared sequencer definitions: FSM state encoding and default parameter values.
package life_pkg;

  typedef enum logic [2:0] {
    S_HALT  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRARR = 3'd2,
    S_RUN   = 3'd3,
    S_WRMEM = 3'd4
  } state_t;

  localparam int DEF_N_POS = 4;
  localparam int DEF_POS_W = 2;
  localparam int DEF_GEN_W = 16;

endpackage

// File: rtl/gen_sequencer_gen_counter.sv
// Completed-generation counter, wraps silently at 2^W.
// Only instantiated when GEN_SEQUENCER_GEN_COUNT_EN is defined.
module gen_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else if (inc) count <= count + W'(1);
  end

endmodule

// File: rtl/gen_sequencer.sv
// Generation sequencer: sweeps N_POS positions through LOAD/WRARR/RUN/WRMEM per generation.
// Optional generation counter compiled in with GEN_SEQUENCER_GEN_COUNT_EN.
//
// state   | meaning
// HALT    | idle, waiting for step or enable
// LOAD    | fetch cells for current pos
// WRARR   | write_array strobe
// RUN     | run strobe
// WRMEM   | write_mem strobe, held until mem_ready
module gen_sequencer
  import life_pkg::*;
#(
  parameter int N_POS = DEF_N_POS,
  parameter int POS_W = DEF_POS_W,
  parameter int GEN_W = DEF_GEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             step,
  input  logic             mem_ready,
  output logic             write_array,
  output logic             run,
  output logic             write_mem,
  output logic [POS_W-1:0] pos,
  output logic             busy,
  output logic             gen_done,
  output logic [GEN_W-1:0] gen_count
);

  state_t           state, state_next;
  logic [POS_W-1:0] pos_next;
  logic             done_next;
  logic             last_pos;

  assign last_pos = (pos == POS_W'(N_POS - 1));

  always_comb begin
    state_next = state;
    pos_next   = pos;
    done_next  = 1'b0;
    case (state)
      S_HALT: begin
        if (step || enable) begin
          state_next = S_LOAD;
          pos_next   = '0;
        end
      end
      S_LOAD:  state_next = S_WRARR;
      S_WRARR: state_next = S_RUN;
      S_RUN:   state_next = S_WRMEM;
      S_WRMEM: begin
        if (mem_ready) begin
          if (last_pos) begin
            pos_next   = '0;
            done_next  = 1'b1;
            state_next = enable ? S_LOAD : S_HALT;
          end else begin
            pos_next   = pos + POS_W'(1);
            state_next = S_LOAD;
          end
        end
      end
      default: begin
        state_next = S_HALT;
        pos_next   = '0;
      end
    endcase
  end

  // Strobes are flopped from the next-state decode so they are glitch-free and exclusive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_HALT;
      pos         <= '0;
      write_array <= 1'b0;
      run         <= 1'b0;
      write_mem   <= 1'b0;
      busy        <= 1'b0;
      gen_done    <= 1'b0;
    end else begin
      state       <= state_next;
      pos         <= pos_next;
      write_array <= (state_next == S_WRARR);
      run         <= (state_next == S_RUN);
      write_mem   <= (state_next == S_WRMEM);
      busy        <= (state_next != S_HALT);
      gen_done    <= done_next;
    end
  end

`ifdef GEN_SEQUENCER_GEN_COUNT_EN
  gen_counter #(.W(GEN_W)) u_gen_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (done_next),
    .count (gen_count)
  );
`else
  assign gen_count = '0;
`endif

endmodule

// File: tb/tb_gen_sequencer.sv
// Self-checking bench for gen_sequencer: directed scenarios plus random stimulus
// against a position/phase reference model; a second instance uses GEN_W=2 for wrap.
module tb_gen_sequencer;

  localparam int N_POS = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic step = 1'b0;
  logic mem_ready = 1'b1;

  logic        write_array, run, write_mem, busy, gen_done;
  logic [1:0]  pos;
  logic [15:0] gen_count;
  logic        write_array2, run2, write_mem2, busy2, gen_done2;
  logic [1:0]  pos2;
  logic [1:0]  gen_count2;

  gen_sequencer #(.N_POS(N_POS), .POS_W(2), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .step(step), .mem_ready(mem_ready),
    .write_array(write_array), .run(run), .write_mem(write_mem), .pos(pos),
    .busy(busy), .gen_done(gen_done), .gen_count(gen_count)
  );

  gen_sequencer #(.N_POS(N_POS), .POS_W(2), .GEN_W(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .step(step), .mem_ready(mem_ready),
    .write_array(write_array2), .run(run2), .write_mem(write_mem2), .pos(pos2),
    .busy(busy2), .gen_done(gen_done2), .gen_count(gen_count2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: within a generation, position p and phase 0..3 (LOAD,WRARR,RUN,WRMEM).
  bit m_active = 0;
  int m_phase = 0;
  int m_pos = 0;
  int m_gens = 0;
  bit m_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_count(input int modulus);
`ifdef GEN_SEQUENCER_GEN_COUNT_EN
    return m_gens % modulus;
`else
    return 0;
`endif
  endfunction

  task automatic model_edge();
    m_done = 0;
    if (!m_active) begin
      if (step || enable) begin
        m_active = 1; m_pos = 0; m_phase = 0;
      end
    end else if (m_phase < 3) begin
      m_phase++;
    end else if (mem_ready) begin
      if (m_pos == N_POS - 1) begin
        m_gens++;
        m_done = 1;
        m_pos = 0;
        m_phase = 0;
        if (!enable) m_active = 0;
      end else begin
        m_pos++;
        m_phase = 0;
      end
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_phase = 0; m_pos = 0; m_gens = 0; m_done = 0;
  endtask

  task automatic check_outputs();
    chk("write_array", write_array, m_active && m_phase == 1);
    chk("run",         run,         m_active && m_phase == 2);
    chk("write_mem",   write_mem,   m_active && m_phase == 3);
    chk("busy",        busy,        m_active);
    chk("pos",         pos,         m_pos);
    chk("gen_done",    gen_done,    m_done);
    chk("gen_count",   gen_count,   exp_count(65536));
    chk("busy_w2",     busy2,       m_active);
    chk("pos_w2",      pos2,        m_pos);
    chk("strobes_w2",  {write_array2, run2, write_mem2},
        {m_active && m_phase == 1, m_active && m_phase == 2, m_active && m_phase == 3});
    chk("gen_done_w2", gen_done2,   m_done);
    chk("gen_count_w2", gen_count2, exp_count(4));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  int n, wm_cnt, dones, last_done, spacing_bad;

  initial begin
    // Reset state
    #3;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    cycle();
    cycle();
    chk("halt_after_reset", busy, 1'b0);

    // Single step, mem_ready high: 16 cycles LOAD to gen_done, then HALT
    step = 1'b1;
    cycle();
    step = 1'b0;
    chk("step_load", busy, 1'b1);
    n = 0;
    while (n < 40) begin
      if (n == 6) step = 1'b1;   // ignored while busy
      cycle();
      step = 1'b0;
      n++;
      if (gen_done) break;
    end
    chk("step_gen_len", n, 16);
    chk("step_halt", busy, 1'b0);
    cycle();
    chk("step_no_repeat", busy, 1'b0);

    // Free run for three generations, enable dropped mid-way through the third
    enable = 1'b1;
    cycle();
    dones = 0; n = 0; last_done = 0; spacing_bad = 0;
    while (n < 100 && dones < 3) begin
      cycle();
      n++;
      if (gen_done) begin
        dones++;
        if (dones > 1 && n - last_done != 16) spacing_bad++;
        last_done = n;
        if (dones == 2) begin
          repeat (5) cycle();
          n += 5;
          enable = 1'b0;
        end
      end
    end
    chk("run3_dones", dones, 3);
    chk("run3_spacing", spacing_bad, 0);
    chk("run3_halt", busy, 1'b0);

    // mem_ready low 5 cycles in WRMEM at pos 2
    step = 1'b1;
    cycle();
    step = 1'b0;
    n = 0; wm_cnt = 0;
    while (n < 60) begin
      cycle();
      n++;
      if (write_mem && pos == 2) wm_cnt++;
      mem_ready = !(wm_cnt >= 1 && wm_cnt <= 5);
      if (gen_done) break;
    end
    mem_ready = 1'b1;
    chk("stall_wm_cycles", wm_cnt, 6);
    chk("stall_gen_len", n, 21);

    // Asynchronous reset in RUN at pos 1
    step = 1'b1;
    cycle();
    step = 1'b0;
    n = 0;
    while (n < 40 && !(run && pos == 1)) begin
      cycle();
      n++;
    end
    chk("reach_run_pos1", run && pos == 1, 1'b1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    #1 reset = 1'b0;
    repeat (3) cycle();
    chk("reset_stays_halt", busy, 1'b0);

    // Random stimulus
    for (int i = 0; i < 800; i++) begin
      enable    = ($urandom_range(0, 3) == 0);
      step      = ($urandom_range(0, 7) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    enable = 1'b0; step = 1'b0; mem_ready = 1'b1;
    n = 0;
    while (n < 40 && busy) begin
      cycle();
      n++;
    end
    chk("final_halt", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
